uart_buf_arbiter: RTL and testbench

UART_BUF_ARBITER -- requirements
Module: uart_buf_arbiter

---
 rtl/uart_buf_arbiter_if.sv | 41 ++++
 rtl/uart_buf_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_buf_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_buf_arbiter_if.sv
// Handshake and RAM bus bundle between uart_buf_arbiter (slave) and its
// user/uart requesters plus the shared ring RAM (master side).
interface uart_buf_arbiter_if #(
  parameter int DEPTH_LOG2 = 8
);
  logic                  i_user_push;
  logic [7:0]            i_user_wdata;
  logic                  o_user_push_ack;
  logic                  i_user_pop;
  logic                  o_user_pop_ack;
  logic [7:0]            o_user_rdata;
  logic                  o_user_rvalid;
  logic                  i_uart_push;
  logic [7:0]            i_uart_wdata;
  logic                  o_uart_push_ack;
  logic                  i_uart_pop;
  logic                  o_uart_pop_ack;
  logic [7:0]            o_uart_rdata;
  logic                  o_uart_rvalid;
  logic [DEPTH_LOG2:0]   o_ram_r_addr;
  logic [7:0]            i_ram_r_data;
  logic [DEPTH_LOG2:0]   o_ram_w_addr;
  logic [7:0]            o_ram_w_data;
  logic                  o_ram_we;

  modport slave (
    input  i_user_push, i_user_wdata, i_user_pop,
    input  i_uart_push, i_uart_wdata, i_uart_pop, i_ram_r_data,
    output o_user_push_ack, o_user_pop_ack, o_user_rdata, o_user_rvalid,
    output o_uart_push_ack, o_uart_pop_ack, o_uart_rdata, o_uart_rvalid,
    output o_ram_r_addr, o_ram_w_addr, o_ram_w_data, o_ram_we
  );

  modport master (
    output i_user_push, i_user_wdata, i_user_pop,
    output i_uart_push, i_uart_wdata, i_uart_pop, i_ram_r_data,
    input  o_user_push_ack, o_user_pop_ack, o_user_rdata, o_user_rvalid,
    input  o_uart_push_ack, o_uart_pop_ack, o_uart_rdata, o_uart_rvalid,
    input  o_ram_r_addr, o_ram_w_addr, o_ram_w_data, o_ram_we
  );
endinterface

// File: rtl/uart_buf_arbiter.sv
// Two ring buffers (RX at MSB=0, TX at MSB=1) sharing one RAM, with round-robin
// arbitration per RAM port. Optional drop counter: define UART_BUF_DROP_COUNT_EN.
module uart_buf_arbiter #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  uart_buf_arbiter_if.slave   bus,
  output logic [DEPTH_LOG2:0] o_rx_count,
  output logic [DEPTH_LOG2:0] o_tx_count,
  output logic                o_rx_overflow,
  input  logic                i_clr_overflow
`ifdef UART_BUF_DROP_COUNT_EN
  ,
  output logic [7:0]          o_drop_count
`endif
);

  localparam logic [DEPTH_LOG2:0]   FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [DEPTH_LOG2-1:0] rxHead_q, rxTail_q, txHead_q, txTail_q;
  logic [DEPTH_LOG2:0]   rxCount_q, rxCount_d, txCount_q, txCount_d;
  logic                  wrLastUser_q, rdLastUser_q;
  logic                  ramWe_q;
  logic [DEPTH_LOG2:0]   ramWAddr_q, ramRAddr_q;
  logic [7:0]            ramWData_q;
  logic                  userRdPend_q, uartRdPend_q;
  logic                  userRvalid_q, uartRvalid_q;
  logic [7:0]            userRdata_q, uartRdata_q;
  logic                  overflow_q;

  logic userPushElig, userPopElig, uartPopElig;
  logic userPushGnt, uartPushGnt, userPopGnt, uartPopGnt;
  logic rxFull, rxWrite, rxDrop;

  assign userPushElig = bus.i_user_push && (txCount_q != FULL);
  assign userPopElig  = bus.i_user_pop  && (rxCount_q != '0);
  assign uartPopElig  = bus.i_uart_pop  && (txCount_q != '0);

  // On contention the side not granted last wins; a lone eligible requester always wins.
  assign userPushGnt = i_rst_n && userPushElig && !(bus.i_uart_push && wrLastUser_q);
  assign uartPushGnt = i_rst_n && bus.i_uart_push && !(userPushElig && !wrLastUser_q);
  assign userPopGnt  = i_rst_n && userPopElig && !(uartPopElig && rdLastUser_q);
  assign uartPopGnt  = i_rst_n && uartPopElig && !(userPopElig && !rdLastUser_q);

  assign rxFull  = (rxCount_q == FULL);
  assign rxWrite = uartPushGnt && !rxFull;
  assign rxDrop  = uartPushGnt && rxFull;

  always_comb begin
    rxCount_d = rxCount_q;
    txCount_d = txCount_q;
    if (rxWrite && !userPopGnt)      rxCount_d = rxCount_q + CNT_ONE;
    else if (!rxWrite && userPopGnt) rxCount_d = rxCount_q - CNT_ONE;
    if (userPushGnt && !uartPopGnt)      txCount_d = txCount_q + CNT_ONE;
    else if (!userPushGnt && uartPopGnt) txCount_d = txCount_q - CNT_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rxHead_q     <= '0;
      rxTail_q     <= '0;
      txHead_q     <= '0;
      txTail_q     <= '0;
      rxCount_q    <= '0;
      txCount_q    <= '0;
      wrLastUser_q <= 1'b0;
      rdLastUser_q <= 1'b0;
      ramWe_q      <= 1'b0;
      ramWAddr_q   <= '0;
      ramWData_q   <= 8'h00;
      ramRAddr_q   <= '0;
      userRdPend_q <= 1'b0;
      uartRdPend_q <= 1'b0;
      userRvalid_q <= 1'b0;
      uartRvalid_q <= 1'b0;
      userRdata_q  <= 8'h00;
      uartRdata_q  <= 8'h00;
      overflow_q   <= 1'b0;
    end else begin
      rxCount_q <= rxCount_d;
      txCount_q <= txCount_d;
      if (rxWrite)     rxTail_q <= rxTail_q + PTR_ONE;
      if (userPopGnt)  rxHead_q <= rxHead_q + PTR_ONE;
      if (userPushGnt) txTail_q <= txTail_q + PTR_ONE;
      if (uartPopGnt)  txHead_q <= txHead_q + PTR_ONE;

      if (userPushGnt)      wrLastUser_q <= 1'b1;
      else if (uartPushGnt) wrLastUser_q <= 1'b0;
      if (userPopGnt)       rdLastUser_q <= 1'b1;
      else if (uartPopGnt)  rdLastUser_q <= 1'b0;

      ramWe_q <= userPushGnt || rxWrite;
      if (userPushGnt) begin
        ramWAddr_q <= {1'b1, txTail_q};
        ramWData_q <= bus.i_user_wdata;
      end else if (rxWrite) begin
        ramWAddr_q <= {1'b0, rxTail_q};
        ramWData_q <= bus.i_uart_wdata;
      end

      // Reads are two-stage: address out next cycle, RAM data back the cycle after.
      if (userPopGnt)      ramRAddr_q <= {1'b0, rxHead_q};
      else if (uartPopGnt) ramRAddr_q <= {1'b1, txHead_q};
      userRdPend_q <= userPopGnt;
      uartRdPend_q <= uartPopGnt;
      userRvalid_q <= userRdPend_q;
      uartRvalid_q <= uartRdPend_q;
      if (userRvalid_q) userRdata_q <= bus.i_ram_r_data;
      if (uartRvalid_q) uartRdata_q <= bus.i_ram_r_data;

      if (rxDrop)              overflow_q <= 1'b1;
      else if (i_clr_overflow) overflow_q <= 1'b0;
    end
  end

`ifdef UART_BUF_DROP_COUNT_EN
  logic [7:0] dropCount_q;

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      dropCount_q <= 8'h00;
    end else if (rxDrop) begin
      if (i_clr_overflow)            dropCount_q <= 8'h01;
      else if (dropCount_q != 8'hFF) dropCount_q <= dropCount_q + 8'h01;
    end else if (i_clr_overflow) begin
      dropCount_q <= 8'h00;
    end
  end

  assign o_drop_count = dropCount_q;
`endif

  assign bus.o_user_push_ack = userPushGnt;
  assign bus.o_uart_push_ack = uartPushGnt;
  assign bus.o_user_pop_ack  = userPopGnt;
  assign bus.o_uart_pop_ack  = uartPopGnt;
  assign bus.o_ram_we        = ramWe_q;
  assign bus.o_ram_w_addr    = ramWAddr_q;
  assign bus.o_ram_w_data    = ramWData_q;
  assign bus.o_ram_r_addr    = ramRAddr_q;
  assign bus.o_user_rvalid   = userRvalid_q;
  assign bus.o_uart_rvalid   = uartRvalid_q;
  assign bus.o_user_rdata    = userRvalid_q ? bus.i_ram_r_data : userRdata_q;
  assign bus.o_uart_rdata    = uartRvalid_q ? bus.i_ram_r_data : uartRdata_q;
  assign o_rx_count          = rxCount_q;
  assign o_tx_count          = txCount_q;
  assign o_rx_overflow       = overflow_q;

endmodule

// File: tb/tb_uart_buf_arbiter.sv
// Bench for uart_buf_arbiter: queue-based ring model checked every cycle, plus
// hand-computed directed checks. Define UART_BUF_DROP_COUNT_EN to cover the drop counter.
module tb_uart_buf_arbiter;
  localparam int DL    = 8;
  localparam int DEPTH = 1 << DL;

  logic        clk = 1'b0;
  logic        rstN;
  logic        clrOvf;
  logic [DL:0] rxCount, txCount;
  logic        rxOverflow;
`ifdef UART_BUF_DROP_COUNT_EN
  logic [7:0]  dropCount;
`endif

  int nChecks = 0;
  int nErrors = 0;

  bit snapUPushAck, snapXPushAck, snapUPopAck, snapXPopAck;

  uart_buf_arbiter_if #(.DEPTH_LOG2(DL)) bus ();

  uart_buf_arbiter #(.DEPTH_LOG2(DL)) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .bus            (bus),
    .o_rx_count     (rxCount),
    .o_tx_count     (txCount),
    .o_rx_overflow  (rxOverflow),
    .i_clr_overflow (clrOvf)
`ifdef UART_BUF_DROP_COUNT_EN
    ,
    .o_drop_count   (dropCount)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one cycle of read latency.
  logic [7:0] mem [0:2*DEPTH-1];
  always @(posedge clk) begin
    if (bus.o_ram_we) mem[bus.o_ram_w_addr] <= bus.o_ram_w_data;
    bus.i_ram_r_data <= mem[bus.o_ram_r_addr];
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of requests, snapshot the combinational acks, then move to the next cycle.
  task automatic applyStimulus(input bit rst, input bit uPush, input int uWd, input bit uPop,
                               input bit xPush, input int xWd, input bit xPop, input bit clr);
    rstN             = rst;
    bus.i_user_push  = uPush;
    bus.i_user_wdata = uWd[7:0];
    bus.i_user_pop   = uPop;
    bus.i_uart_push  = xPush;
    bus.i_uart_wdata = xWd[7:0];
    bus.i_uart_pop   = xPop;
    clrOvf           = clr;
    #1;
    snapUPushAck = bus.o_user_push_ack;
    snapXPushAck = bus.o_uart_push_ack;
    snapUPopAck  = bus.o_user_pop_ack;
    snapXPopAck  = bus.o_uart_pop_ack;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Behavioural model: each ring is a queue of bytes, addresses come from running
  // write/read totals modulo the ring size, and reads surface two cycles after grant.
  logic [7:0] rxQ[$];
  logic [7:0] txQ[$];
  int rxWr = 0, rxRd = 0, txWr = 0, txRd = 0;
  bit mOvf = 0;
  int mDrop = 0;
  bit wrLastUser = 0, rdLastUser = 0;
  bit expWe = 0;
  int expWAddr = 0, expWData = 0, expRAddr = 0;
  bit s1U = 0, s1X = 0, s2U = 0, s2X = 0;
  int s1UData = 0, s1XData = 0, s2UData = 0, s2XData = 0;
  int heldU = 0, heldX = 0;

  always @(negedge clk) begin : compare
    bit eUPush, eUPop, eXPop, gUPush, gXPush, gUPop, gXPop, full;
    eUPush = bus.i_user_push && (txQ.size() != DEPTH);
    eUPop  = bus.i_user_pop && (rxQ.size() != 0);
    eXPop  = bus.i_uart_pop && (txQ.size() != 0);
    gUPush = 0; gXPush = 0; gUPop = 0; gXPop = 0;
    if (rstN) begin
      if (eUPush && bus.i_uart_push) begin gUPush = !wrLastUser; gXPush = wrLastUser; end
      else begin gUPush = eUPush; gXPush = bus.i_uart_push; end
      if (eUPop && eXPop) begin gUPop = !rdLastUser; gXPop = rdLastUser; end
      else begin gUPop = eUPop; gXPop = eXPop; end
    end

    checkOutput("user_push_ack", bus.o_user_push_ack, gUPush);
    checkOutput("uart_push_ack", bus.o_uart_push_ack, gXPush);
    checkOutput("user_pop_ack", bus.o_user_pop_ack, gUPop);
    checkOutput("uart_pop_ack", bus.o_uart_pop_ack, gXPop);
    checkOutput("rx_count", rxCount, rxQ.size());
    checkOutput("tx_count", txCount, txQ.size());
    checkOutput("rx_overflow", rxOverflow, mOvf);
    checkOutput("ram_we", bus.o_ram_we, expWe);
    if (expWe) begin
      checkOutput("ram_w_addr", bus.o_ram_w_addr, expWAddr);
      checkOutput("ram_w_data", bus.o_ram_w_data, expWData);
    end
    if (s1U || s1X) checkOutput("ram_r_addr", bus.o_ram_r_addr, expRAddr);
    checkOutput("user_rvalid", bus.o_user_rvalid, s2U);
    checkOutput("uart_rvalid", bus.o_uart_rvalid, s2X);
    checkOutput("user_rdata", bus.o_user_rdata, s2U ? s2UData : heldU);
    checkOutput("uart_rdata", bus.o_uart_rdata, s2X ? s2XData : heldX);
`ifdef UART_BUF_DROP_COUNT_EN
    checkOutput("drop_count", dropCount, mDrop);
`endif

    if (!rstN) begin
      rxQ.delete(); txQ.delete();
      rxWr = 0; rxRd = 0; txWr = 0; txRd = 0;
      mOvf = 0; mDrop = 0; wrLastUser = 0; rdLastUser = 0;
      expWe = 0; s1U = 0; s1X = 0; s2U = 0; s2X = 0;
      heldU = 0; heldX = 0;
    end else begin
      full = (rxQ.size() == DEPTH);
      if (s2U) heldU = s2UData;
      if (s2X) heldX = s2XData;
      s2U = s1U; s2UData = s1UData;
      s2X = s1X; s2XData = s1XData;
      s1U = gUPop; s1X = gXPop;
      if (gUPop) begin
        s1UData = rxQ.pop_front(); expRAddr = rxRd; rxRd = (rxRd + 1) % DEPTH;
      end
      if (gXPop) begin
        s1XData = txQ.pop_front(); expRAddr = DEPTH + txRd; txRd = (txRd + 1) % DEPTH;
      end
      expWe = 0;
      if (gUPush) begin
        expWe = 1; expWAddr = DEPTH + txWr; expWData = bus.i_user_wdata;
        txQ.push_back(bus.i_user_wdata); txWr = (txWr + 1) % DEPTH;
      end
      if (gXPush && full) begin
        mOvf  = 1;
        mDrop = clrOvf ? 1 : ((mDrop == 255) ? 255 : mDrop + 1);
      end else begin
        if (gXPush) begin
          expWe = 1; expWAddr = rxWr; expWData = bus.i_uart_wdata;
          rxQ.push_back(bus.i_uart_wdata); rxWr = (rxWr + 1) % DEPTH;
        end
        if (clrOvf) begin mOvf = 0; mDrop = 0; end
      end
      if (gUPush) wrLastUser = 1; else if (gXPush) wrLastUser = 0;
      if (gUPop)  rdLastUser = 1; else if (gXPop)  rdLastUser = 0;
    end
  end

  initial begin : stimulus
    bit expUAck[3];
    bit expXAck[3];
    expUAck = '{1, 0, 1};
    expXAck = '{0, 1, 0};
    rstN = 0; clrOvf = 0;
    bus.i_user_push = 0; bus.i_user_wdata = 0; bus.i_user_pop = 0;
    bus.i_uart_push = 0; bus.i_uart_wdata = 0; bus.i_uart_pop = 0;
    @(posedge clk);
    #1;
    doReset();
    checkOutput("reset rx_count", rxCount, 0);
    checkOutput("reset tx_count", txCount, 0);
    checkOutput("reset rx_overflow", rxOverflow, 0);
    checkOutput("reset ram_we", bus.o_ram_we, 0);
    checkOutput("reset user_rdata", bus.o_user_rdata, 8'h00);

    // Two TX bytes, then the transmitter fetches the first.
    applyStimulus(1, 1, 8'h41, 0, 0, 0, 0, 0);
    checkOutput("push41 ack", snapUPushAck, 1);
    checkOutput("push41 we", bus.o_ram_we, 1);
    checkOutput("push41 addr", bus.o_ram_w_addr, 9'h100);
    checkOutput("push41 data", bus.o_ram_w_data, 8'h41);
    applyStimulus(1, 1, 8'h42, 0, 0, 0, 0, 0);
    checkOutput("push42 addr", bus.o_ram_w_addr, 9'h101);
    checkOutput("push42 tx_count", txCount, 2);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("pop ack", snapXPopAck, 1);
    checkOutput("pop r_addr", bus.o_ram_r_addr, 9'h100);
    idle(1);
    checkOutput("pop rvalid", bus.o_uart_rvalid, 1);
    checkOutput("pop rdata", bus.o_uart_rdata, 8'h41);
    idle(2);

    // Contended write port alternates starting with the user side.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 8'hA0 + i, 0, 1, 8'hB0 + i, 0, 0);
      checkOutput("rr user_push_ack", snapUPushAck, expUAck[i]);
      checkOutput("rr uart_push_ack", snapXPushAck, expXAck[i]);
    end
    checkOutput("rr tx_count", txCount, 2);
    checkOutput("rr rx_count", rxCount, 1);
    idle(2);

    // Fill RX, overflow, clear, then drain while TX pops stay ineligible.
    doReset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 0, 1, i, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 8'h55, 0, 0);
    checkOutput("drop ack", snapXPushAck, 1);
    checkOutput("drop we", bus.o_ram_we, 0);
    checkOutput("drop rx_count", rxCount, 256);
    checkOutput("drop overflow", rxOverflow, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("clr overflow", rxOverflow, 0);
    applyStimulus(1, 0, 0, 0, 1, 8'h66, 0, 1);
    checkOutput("clr vs drop overflow", rxOverflow, 1);
    applyStimulus(1, 0, 0, 1, 1, 8'h77, 0, 0);
    checkOutput("full pop+push rx_count", rxCount, 255);
    for (int i = 0; i < 260; i++) applyStimulus(1, 0, 0, 1, 0, 0, 1, 0);
    checkOutput("drained rx_count", rxCount, 0);
    idle(2);

    // Stream 300 bytes through TX so both pointers wrap.
    doReset();
    for (int i = 0; i < 300; i++)
      applyStimulus(1, 1, (i * 37 + 5) & 8'hFF, 0, 0, 0, (i % 3) != 0, 0);
    for (int i = 0; i < 120; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("wrap tx_count", txCount, 0);
    idle(2);

    // Reset one cycle after a pop grant kills the pending read.
    doReset();
    applyStimulus(1, 1, 8'h11, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 8'h22, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("pre-reset pop ack", snapXPopAck, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post-reset rvalid", bus.o_uart_rvalid, 0);
    checkOutput("post-reset tx_count", txCount, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post-reset late rvalid", bus.o_uart_rvalid, 0);
    applyStimulus(1, 1, 8'h77, 0, 0, 0, 0, 0);
    checkOutput("post-reset we", bus.o_ram_we, 1);
    checkOutput("post-reset addr", bus.o_ram_w_addr, 9'h100);
    idle(2);

`ifdef UART_BUF_DROP_COUNT_EN
    doReset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 0, 1, i, 0, 0);
    for (int i = 0; i < 300; i++) applyStimulus(1, 0, 0, 0, 1, 8'hEE, 0, 0);
    checkOutput("drop_count saturated", dropCount, 8'hFF);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("drop_count cleared", dropCount, 8'h00);
    idle(2);
`endif

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
